// File: rtl/ldpc_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_frame_source
// Description : Frame replay source for the LDPC datapath. One frame of up to
//               DEPTH words is written into on-chip RAM through a config
//               port and then streamed over valid/ready with first/last-word
//               markers, an optional inter-frame gap, and single-shot or
//               loop mode.
// Ports       : clk, rst_n            clock, async active-low reset
//               wr_en/wr_addr/wr_data RAM config write port (idle only)
//               start, stop           control pulses
//               loop_mode, frame_len, gap_cycles  frame setup, latched at start
//               m_valid/m_ready/m_data/m_sof/m_eof  output stream
//               busy, frame_cnt, err  status
// Revision    : 1.0  initial release
// ============================================================================
module ldpc_frame_source #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 17,
    parameter int ADDR_W = 5,
    parameter int GAP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [ADDR_W:0]   frame_len,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_fetch  = 2'd1;
    localparam logic [1:0] c_st_stream = 2'd2;
    localparam logic [1:0] c_st_gap    = 2'd3;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rd_addr;    // address of the word to load on the next read
    logic [ADDR_W-1:0] r_beat;       // index of the word currently on m_data
    logic [ADDR_W-1:0] r_last_idx;   // frame_len-1, latched at start
    logic [GAP_W-1:0]  r_gap_len;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_loop;
    logic              r_stop_pend;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_ram_q;

    logic              w_busy;
    logic              w_valid;
    logic              w_accept;
    logic              w_last;
    logic              w_len_bad;
    logic              w_start_bad;
    logic              w_wr_bad;
    logic              w_wr_ok;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_sel;
    logic [ADDR_W-1:0] w_rd_next;

    assign w_busy      = (r_state != c_st_idle);
    assign w_valid     = (r_state == c_st_stream);
    assign w_accept    = w_valid && m_ready;
    assign w_last      = w_accept && (r_beat == r_last_idx);
    assign w_len_bad   = (frame_len == '0) || (frame_len > c_depth);
    assign w_start_bad = (r_state == c_st_idle) && start && w_len_bad;
    assign w_wr_bad    = wr_en && (w_busy || ({1'b0, wr_addr} >= c_depth));
    assign w_wr_ok     = wr_en && !w_bad_or_busy_n();

    // Read port: FETCH always loads word 0, STREAM loads the prefetched
    // address on every accepted beat so the next word appears one cycle later.
    assign w_rd_en   = (r_state == c_st_fetch) || w_accept;
    assign w_rd_sel  = (r_state == c_st_fetch) ? '0 : r_rd_addr;
    assign w_rd_next = (w_rd_sel == r_last_idx) ? '0 : w_rd_sel + 1'b1;

    function automatic logic w_bad_or_busy_n();
        return w_busy || ({1'b0, wr_addr} >= c_depth);
    endfunction

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // RAM output register, doubles as the m_data holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_q <= '0;
        end else if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_rd_addr   <= '0;
            r_beat      <= '0;
            r_last_idx  <= '0;
            r_gap_len   <= '0;
            r_gap_cnt   <= '0;
            r_loop      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_wr_bad || w_start_bad;

            if (w_rd_en) begin
                r_rd_addr <= w_rd_next;
            end

            case (r_state)
                c_st_idle: begin
                    r_stop_pend <= 1'b0;
                    if (start && !w_len_bad) begin
                        r_last_idx  <= ADDR_W'(frame_len - 1'b1);
                        r_gap_len   <= gap_cycles;
                        r_loop      <= loop_mode;
                        r_frame_cnt <= '0;
                        r_rd_addr   <= '0;
                        r_state     <= c_st_fetch;
                    end
                end

                c_st_fetch: begin
                    r_beat  <= '0;
                    r_state <= c_st_stream;
                end

                c_st_stream: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_accept) begin
                        r_beat <= (r_beat == r_last_idx) ? '0 : r_beat + 1'b1;
                    end
                    if (w_last) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        // A stop arriving with the last beat still ends the run
                        if (r_stop_pend || stop || !r_loop) begin
                            r_stop_pend <= 1'b0;
                            r_state     <= c_st_idle;
                        end else if (r_gap_len == '0) begin
                            r_state <= c_st_stream;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= c_st_gap;
                        end
                    end
                end

                c_st_gap: begin
                    if (stop) begin
                        r_stop_pend <= 1'b0;
                        r_state     <= c_st_idle;
                    end else if (r_gap_cnt == r_gap_len - 1'b1) begin
                        r_state <= c_st_fetch;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign m_valid   = w_valid;
    assign m_data    = r_ram_q;
    assign m_sof     = w_valid && (r_beat == '0);
    assign m_eof     = w_valid && (r_beat == r_last_idx);
    assign busy      = w_busy;
    assign frame_cnt = r_frame_cnt;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldpc_frame_source
// Description : Directed self-checking bench for ldpc_frame_source. A
//               negedge monitor records every accepted beat and the number
//               of invalid cycles between each accepted eof and the next
//               sof; scenarios compare these against hand-derived values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ldpc_frame_source;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 17;
    localparam int ADDR_W = 5;
    localparam int GAP_W  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_mode = 1'b0;
    logic [ADDR_W:0]   frame_len = '0;
    logic [GAP_W-1:0]  gap_cycles = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_eof;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] beat_q[$];   // {sof, eof, data}
    int          gap_q[$];
    logic        gap_arm = 1'b0;
    int          gap_run = 0;

    ldpc_frame_source #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .GAP_W(GAP_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop_mode(loop_mode),
        .frame_len(frame_len), .gap_cycles(gap_cycles),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eof(m_eof),
        .busy(busy), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Beats are accepted on the posedge following a negedge where valid&&ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gap_arm) begin
                if (m_valid) begin
                    if (m_sof) gap_q.push_back(gap_run);
                    gap_arm = 1'b0;
                end else begin
                    gap_run++;
                end
            end
            if (m_valid && m_ready) begin
                beat_q.push_back({m_sof, m_eof, m_data});
                if (m_eof) begin
                    gap_arm = 1'b1;
                    gap_run = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        beat_q.delete();
        gap_q.delete();
        gap_arm = 1'b0;
        gap_run = 0;
    endtask

    task automatic write_word(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = DATA_W'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_frame(input int len, input int gap, input logic lp);
        frame_len  = (ADDR_W+1)'(len);
        gap_cycles = GAP_W'(gap);
        loop_mode  = lp;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_cnt(input string tag, input int target, input int budget);
        int n = 0;
        while (frame_cnt != CNT_W'(target) && n < budget) begin
            tick();
            n++;
        end
        check(tag, frame_cnt, target);
    endtask

    task automatic check_frames(input string tag, input int n_beats, input int len, input int base);
        int errs = 0;
        check({tag, "_nbeats"}, beat_q.size(), n_beats);
        foreach (beat_q[i]) begin
            int k;
            k = i % len;
            if (beat_q[i][15:0] !== 16'(base + k) ||
                beat_q[i][17] !== (k == 0) ||
                beat_q[i][16] !== (k == len - 1)) errs++;
        end
        check({tag, "_seq_errs"}, errs, 0);
    endtask

    task automatic check_gaps(input string tag, input int n, input int val);
        int errs = 0;
        check({tag, "_ngaps"}, gap_q.size(), n);
        foreach (gap_q[i]) if (gap_q[i] != val) errs++;
        check({tag, "_gap_errs"}, errs, 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_err", err, 0);
        check("rst_data", m_data, 0);
        check("rst_sof_eof", {m_sof, m_eof}, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- 1: full-depth single frame ----------------
        for (int i = 0; i < DEPTH; i++) write_word(i, i);
        check("s1_no_err", err, 0);
        clear_sb();
        m_ready = 1'b1;
        start_frame(17, 0, 1'b0);
        check("s1_fetch_busy", busy, 1);
        check("s1_fetch_novalid", m_valid, 0);
        tick();
        check("s1_first_valid", m_valid, 1);
        check("s1_first_word", {m_sof, m_data}, {1'b1, 16'h0000});
        wait_idle("s1_done", 100);
        check_frames("s1", 17, 17, 0);
        check("s1_cnt", frame_cnt, 1);

        // ---------------- 2: loop, no gap, stop in frame 3 ----------------
        for (int i = 0; i < 4; i++) write_word(i, 16'h00A0 + i);
        clear_sb();
        start_frame(4, 0, 1'b1);
        wait_cnt("s2_reach2", 2, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("s2_still_busy", busy, 1);
        wait_idle("s2_done", 100);
        check("s2_cnt", frame_cnt, 3);
        check_frames("s2", 12, 4, 16'h00A0);
        check_gaps("s2", 2, 0);

        // ---------------- 3: loop with gap 3 ----------------
        clear_sb();
        start_frame(2, 3, 1'b1);
        wait_cnt("s3_reach3", 3, 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("s3_stop_in_gap", busy, 0);
        check("s3_cnt", frame_cnt, 3);
        check_frames("s3", 6, 2, 16'h00A0);
        check_gaps("s3", 2, 4);

        // ---------------- 4: random backpressure ----------------
        for (int i = 0; i < 4; i++) write_word(i, i);
        clear_sb();
        start_frame(17, 0, 1'b0);
        begin
            logic [17:0] prev;
            logic        prev_stall;
            int          stall_errs;
            int          stalls;
            int          n;
            prev = '0; prev_stall = 1'b0; stall_errs = 0; stalls = 0; n = 0;
            while (busy && n < 600) begin
                if (prev_stall && ({m_sof, m_eof, m_data} !== prev || !m_valid)) stall_errs++;
                m_ready    = 1'($urandom_range(0, 1));
                prev       = {m_sof, m_eof, m_data};
                prev_stall = m_valid && !m_ready;
                if (prev_stall) stalls++;
                tick();
                n++;
            end
            m_ready = 1'b1;
            check("s4_done", busy, 0);
            check("s4_stall_stable_errs", stall_errs, 0);
            check("s4_saw_stalls", (stalls > 0), 1);
        end
        check_frames("s4", 17, 17, 0);
        check("s4_cnt", frame_cnt, 1);

        // ---------------- 5: error cases ----------------
        start_frame(0, 0, 1'b0);
        check("s5_len0_err", err, 1);
        check("s5_len0_busy", busy, 0);
        tick();
        check("s5_len0_pulse", err, 0);
        start_frame(18, 0, 1'b0);
        check("s5_len18_err", err, 1);
        check("s5_len18_busy", busy, 0);
        tick();
        check("s5_len18_pulse", err, 0);
        write_word(20, 16'hBEEF);
        check("s5_oob_wr_err", err, 1);
        start_frame(17, 0, 1'b0);
        repeat (3) tick();
        write_word(5, 16'hDEAD);
        check("s5_busy_wr_err", err, 1);
        wait_idle("s5_done1", 100);
        clear_sb();
        start_frame(17, 0, 1'b0);
        wait_idle("s5_done2", 100);
        check_frames("s5", 17, 17, 0);

        // ---------------- 6: reset mid-frame ----------------
        clear_sb();
        start_frame(4, 0, 1'b1);
        begin
            int n = 0;
            while (beat_q.size() < 5 && n < 100) begin
                tick();
                n++;
            end
        end
        check("s6_beats_pre", beat_q.size(), 5);
        check("s6_cnt_pre", frame_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_valid", m_valid, 0);
        check("s6_async_cnt", frame_cnt, 0);
        check("s6_async_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_sb();
        tick();
        start_frame(17, 0, 1'b0);
        tick();
        check("s6_restart_word0", {m_valid, m_sof, m_data}, {2'b11, 16'h0000});
        wait_idle("s6_done", 100);
        check_frames("s6", 17, 17, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a scenario stalls beyond its own bounds
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
